draw_rect_img: RTL and testbench

DRAW_RECT_IMG -- requirements
Module: draw_rect_img

---
 rtl/draw_rect_img.sv | 114 +++++++++++
 tb/tb_draw_rect_img.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_img.sv
// Overlays a keyed bitmap image on the VGA stream at a position latched once per frame.
// Three-stage pipeline: address/hit, ROM read, composite.
module draw_rect_img #(
  parameter int unsigned RECT_WIDTH  = 48,
  parameter int unsigned RECT_HEIGHT = 64,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } timing_t;

  logic [11:0] x_lat_q, y_lat_q;
  logic        vblnk_prev_q;
  logic [11:0] addr_q;
  logic        hit1_q, hit2_q;
  timing_t     t_in, t1_q, t2_q, t3_q;

  logic [12:0] hc13, vc13, x13, y13, x_end, y_end;
  logic [11:0] col, row;
  logic        hit_d;
  logic [11:0] rgb_d;

  assign t_in = '{hc: hcount_in, vc: vcount_in, hs: hsync_in, hb: hblnk_in,
                  vs: vsync_in, vb: vblnk_in, rgb: rgb_in};

  // Bounds evaluated at 13 bits so a rectangle near 12'hFFF cannot wrap into view.
  always_comb begin
    hc13  = {2'b00, hcount_in};
    vc13  = {2'b00, vcount_in};
    x13   = {1'b0, x_lat_q};
    y13   = {1'b0, y_lat_q};
    x_end = x13 + 13'(RECT_WIDTH);
    y_end = y13 + 13'(RECT_HEIGHT);
    col   = {1'b0, hcount_in} - x_lat_q;
    row   = {1'b0, vcount_in} - y_lat_q;
    hit_d = !hblnk_in && !vblnk_in && (hc13 >= x13) && (hc13 < x_end)
            && (vc13 >= y13) && (vc13 < y_end);
  end

  always_comb begin
    rgb_d = t2_q.rgb;
    if (t2_q.hb || t2_q.vb) begin
      rgb_d = 12'h000;
    end else if (hit2_q && (rgb_pixel != KEY_COLOR)) begin
      rgb_d = rgb_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      vblnk_prev_q <= 1'b0;
      addr_q       <= '0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      t1_q         <= '0;
      t2_q         <= '0;
      t3_q         <= '0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      // Position only moves at the start of vertical blanking to avoid tearing.
      if (vblnk_in && !vblnk_prev_q) begin
        x_lat_q <= xpos;
        y_lat_q <= ypos;
      end
      if (hit_d) addr_q <= {row[5:0], col[5:0]};
      hit1_q <= hit_d;
      t1_q   <= t_in;
      hit2_q <= hit1_q;
      t2_q   <= t1_q;
      t3_q   <= '{hc: t2_q.hc, vc: t2_q.vc, hs: t2_q.hs, hb: t2_q.hb,
                  vs: t2_q.vs, vb: t2_q.vb, rgb: rgb_d};
    end
  end

  assign pixel_addr = addr_q;
  assign hcount_out = t3_q.hc;
  assign vcount_out = t3_q.vc;
  assign hsync_out  = t3_q.hs;
  assign hblnk_out  = t3_q.hb;
  assign vsync_out  = t3_q.vs;
  assign vblnk_out  = t3_q.vb;
  assign rgb_out    = t3_q.rgb;

endmodule

// File: tb/tb_draw_rect_img.sv
// Randomized + directed bench for draw_rect_img with a frame-level reference model
// and a queue-based scoreboard fed by the driver and drained by a monitor.
module tb_draw_rect_img;

  localparam int W = 48;
  localparam int H = 64;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0, rgb_pixel = '0;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_rect_img #(.RECT_WIDTH(W), .RECT_HEIGHT(H), .KEY_COLOR(KEY)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Image ROM with a one-cycle registered read.
  logic [11:0] rom [4096];
  always @(posedge clk) rgb_pixel <= rom[pixel_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          chk;
    logic [10:0] hc, vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int          due;
    bit          chk;
    logic [11:0] addr;
  } addr_t;

  out_t  q_out[$];
  addr_t q_addr[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model state: latched corner, previous vblnk and last ROM address.
  int          mx = 0, my = 0;
  bit          mprev = 0;
  logic [11:0] maddr = '0;

  task automatic drive(input int h, input int v, input bit hb, input bit vb,
                       input logic [11:0] rgb, input logic [11:0] xp, input logic [11:0] yp,
                       input bit r, input bit chk);
    out_t  o;
    addr_t a;
    bit    hit;
    bit    hs, vs;
    @(negedge clk);
    hs = 1'($urandom);
    vs = 1'($urandom);
    rst = r; hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = vb;
    hsync_in = hs; vsync_in = vs; rgb_in = rgb; xpos = xp; ypos = yp;
    o.due = cyc + 3; o.chk = chk;
    a.due = cyc + 1; a.chk = chk;
    if (r) begin
      mx = 0; my = 0; mprev = 0; maddr = '0;
      o.hc = '0; o.vc = '0; o.hs = 0; o.hb = 0; o.vs = 0; o.vb = 0; o.rgb = '0;
    end else begin
      hit = !hb && !vb && (h >= mx) && (h < mx + W) && (v >= my) && (v < my + H);
      if (hit) maddr = 12'(((v - my) << 6) + (h - mx));
      o.hc = 11'(h); o.vc = 11'(v); o.hs = hs; o.hb = hb; o.vs = vs; o.vb = vb;
      if (hb || vb) o.rgb = 12'h000;
      else if (hit && rom[maddr] != KEY) o.rgb = rom[maddr];
      else o.rgb = rgb;
      if (vb && !mprev) begin
        mx = int'(xp); my = int'(yp);
      end
      mprev = vb;
    end
    a.addr = maddr;
    q_out.push_back(o);
    q_addr.push_back(a);
  endtask

  task automatic vrise(input logic [11:0] xp, input logic [11:0] yp);
    drive(0, 0, 1'b0, 1'b0, 12'h123, xp, yp, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b1, 12'h123, xp, yp, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 12'h123, xp, yp, 1'b0, 1'b1);
  endtask

  task automatic pix(input int h, input int v);
    drive(h, v, 1'b0, 1'b0, 12'($urandom), xpos, ypos, 1'b0, 1'b1);
  endtask

  // Monitor: compare whatever the scoreboard says is due after this edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
        addr_t a;
        a = q_addr.pop_front();
        if (a.chk) begin
          tests++;
          if (a.due != cyc || pixel_addr !== a.addr) begin
            fails++;
            $display("FAIL pixel_addr cyc=%0d got %h exp %h", cyc, pixel_addr, a.addr);
          end
        end
      end
      while (q_out.size() > 0 && q_out[0].due <= cyc) begin
        out_t o;
        o = q_out.pop_front();
        if (o.chk) begin
          tests++;
          if (o.due != cyc || hcount_out !== o.hc || vcount_out !== o.vc ||
              hsync_out !== o.hs || hblnk_out !== o.hb || vsync_out !== o.vs ||
              vblnk_out !== o.vb || rgb_out !== o.rgb) begin
            fails++;
            $display("FAIL outputs cyc=%0d got hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h exp hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h",
                     cyc, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                     vblnk_out, rgb_out, o.hc, o.vc, o.hs, o.hb, o.vs, o.vb, o.rgb);
          end
        end
      end
    end
  end

  initial begin
    int h, v;
    for (int i = 0; i < 4096; i++) begin
      rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    end
    rom[12'h000] = KEY;
    rom[{6'd63, 6'd47}] = 12'h0F0;
    rom[{6'd0, 6'd1}] = 12'h0F0;

    // Reset held two cycles, then release mid-frame.
    drive(500, 300, 1'b0, 1'b0, 12'hABC, 12'd100, 12'd50, 1'b1, 1'b1);
    drive(501, 300, 1'b0, 1'b0, 12'hABC, 12'd100, 12'd50, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) pix(10 + i, 20);

    // Corner and far-corner addressing, one past each edge.
    vrise(12'd100, 12'd50);
    pix(100, 50); pix(101, 50); pix(147, 113); pix(148, 113);
    pix(99, 50); pix(100, 49); pix(120, 114);

    // Position change mid-frame is ignored until the next vblnk rise.
    vrise(12'd10, 12'd50);
    xpos = 12'd300;
    pix(10, 60); pix(300, 60); pix(57, 60);
    drive(0, 0, 1'b0, 1'b0, 12'h0, 12'd10, 12'd50, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b1, 12'h0, 12'd300, 12'd50, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 12'h0, 12'd300, 12'd50, 1'b0, 1'b1);
    pix(10, 60); pix(300, 60); pix(347, 60); pix(348, 60);

    // Clipping at the bottom-right of the visible area.
    vrise(12'd780, 12'd580);
    pix(780, 580); pix(799, 599);
    drive(800, 599, 1'b1, 1'b0, 12'h555, 12'd780, 12'd580, 1'b0, 1'b1);
    drive(780, 600, 1'b0, 1'b1, 12'h555, 12'd780, 12'd580, 1'b0, 1'b1);
    pix(0, 0); pix(5, 5);

    // Out-of-range corner never hits.
    vrise(12'hFFF, 12'hFFF);
    pix(2047, 2047); pix(0, 0); pix(63, 63);

    // Randomized traffic around the latched rectangle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        for (int k = 0; k < 3; k++) drive(0, 0, 1'b0, 1'b0, 12'h0, 12'd0, 12'd0, 1'b0, 1'b0);
        drive(7, 7, 1'b0, 1'b0, 12'h777, 12'd0, 12'd0, 1'b1, 1'b1);
        drive(8, 7, 1'b0, 1'b0, 12'h777, 12'd0, 12'd0, 1'b1, 1'b1);
      end
      if ($urandom_range(0, 99) == 0) begin
        vrise(($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 850)),
              ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 650)));
      end else begin
        if (mx > 2047) h = $urandom_range(0, 2047);
        else h = mx + $urandom_range(0, W + 20) - 5;
        if (my > 2047) v = $urandom_range(0, 2047);
        else v = my + $urandom_range(0, H + 10) - 5;
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        drive(h, v, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              12'($urandom), 12'($urandom_range(0, 850)), 12'($urandom_range(0, 650)),
              1'b0, 1'b1);
      end
    end

    for (int i = 0; i < 20 && (q_out.size() > 0 || q_addr.size() > 0); i++) begin
      @(posedge clk);
    end
    #2;
    if (q_out.size() > 0 || q_addr.size() > 0) begin
      fails++;
      $display("FAIL drain got %0d pending exp 0 pending", q_out.size() + q_addr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
